// File: rtl/load_store_queue_pkg.sv
// Shared types for the load/store queue: opcodes, FSM states, the queue entry
// layout and the CDB operand-capture rule used by every slot.
package load_store_queue_pkg;

  localparam int LSQ_TAG_WIDTH  = 6;
  localparam int LSQ_DATA_WIDTH = 32;

  localparam logic [1:0] LS_OP_NONE  = 2'b00;
  localparam logic [1:0] LS_OP_LOAD  = 2'b01;
  localparam logic [1:0] LS_OP_STORE = 2'b10;

  localparam logic [LSQ_TAG_WIDTH-1:0] TAG_READY = '0;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } lsq_state_t;

  typedef struct packed {
    logic                      valid;
    logic [1:0]                op;
    logic [LSQ_TAG_WIDTH-1:0]  tag;
    logic [LSQ_DATA_WIDTH-1:0] base;
    logic [LSQ_TAG_WIDTH-1:0]  base_tag;
    logic [LSQ_DATA_WIDTH-1:0] sdata;
    logic [LSQ_TAG_WIDTH-1:0]  sdata_tag;
    logic [LSQ_DATA_WIDTH-1:0] imm;
  } lsq_entry_t;

  localparam int ENTRY_W = $bits(lsq_entry_t);

  // A live broadcast replaces any operand still waiting on that producer tag.
  function automatic lsq_entry_t cdb_capture(
    input lsq_entry_t                e,
    input logic                      live,
    input logic [LSQ_TAG_WIDTH-1:0]  tag,
    input logic [LSQ_DATA_WIDTH-1:0] data
  );
    lsq_entry_t r;
    r = e;
    if (live && (e.base_tag == tag)) begin
      r.base     = data;
      r.base_tag = TAG_READY;
    end
    if (live && (e.sdata_tag == tag)) begin
      r.sdata     = data;
      r.sdata_tag = TAG_READY;
    end
    return r;
  endfunction

  // Stores additionally need their data operand before they may go to memory.
  function automatic logic entry_issuable(input lsq_entry_t e);
    return e.valid && (e.base_tag == TAG_READY) &&
           ((e.op != LS_OP_STORE) || (e.sdata_tag == TAG_READY));
  endfunction

endpackage

// File: rtl/load_store_queue_entry.sv
// One queue slot: holds a dispatched memory op and snoops the CDB so that
// pending base/store-data operands fill in while the op waits.
module lsq_entry
  import load_store_queue_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr,
  input  logic [ENTRY_W-1:0]        i_wr_entry,
  input  logic                      i_clr,
  input  logic                      i_cdb_valid,
  input  logic [LSQ_TAG_WIDTH-1:0]  i_cdb_tag,
  input  logic [LSQ_DATA_WIDTH-1:0] i_cdb_data,
  output logic [ENTRY_W-1:0]        o_entry
);

  lsq_entry_t r_entry;
  lsq_entry_t w_wr_captured;
  lsq_entry_t w_snooped;
  logic       w_cdb_live;

  // Tag 0 means "value present", so a zero-tag broadcast must never match.
  assign w_cdb_live = i_cdb_valid && (i_cdb_tag != TAG_READY);

  always_comb begin
    w_wr_captured = cdb_capture(lsq_entry_t'(i_wr_entry), w_cdb_live, i_cdb_tag, i_cdb_data);
    w_snooped     = cdb_capture(r_entry, w_cdb_live, i_cdb_tag, i_cdb_data);
  end

  // Write and clear never target the same slot: that needs head==tail with
  // the queue both non-empty and not full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= '0;
    end else if (i_wr) begin
      r_entry <= w_wr_captured;
    end else if (i_clr) begin
      r_entry.valid <= 1'b0;
    end else if (r_entry.valid) begin
      r_entry <= w_snooped;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue feeding Data_Memory: dispatched ops wait for
// operands, then the head issues via the LS_ready/LS_done handshake.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = LSQ_TAG_WIDTH,
  parameter int DATA_WIDTH = LSQ_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [1:0]            disp_opcode,
  input  logic [TAG_WIDTH-1:0]  disp_tag,
  input  logic [DATA_WIDTH-1:0] disp_base_val,
  input  logic [TAG_WIDTH-1:0]  disp_base_tag,
  input  logic [DATA_WIDTH-1:0] disp_sdata_val,
  input  logic [TAG_WIDTH-1:0]  disp_sdata_tag,
  input  logic [DATA_WIDTH-1:0] disp_imm,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic [1:0]            mem_opcode,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [TAG_WIDTH-1:0]  mem_tag,
  output logic                  mem_ls_ready,
  output logic                  mem_ls_done,
  input  logic                  mem_ls_ready_back,
  input  logic                  mem_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  lsq_state_t       r_state;
  lsq_state_t       w_state_next;

  lsq_entry_t         w_dispatch_entry;
  logic [ENTRY_W-1:0] w_slot_flat [DEPTH];
  lsq_entry_t         w_head;
  logic               w_head_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_ls_ready;
  logic               w_ls_done;

  assign disp_ready = (r_count != FULL_COUNT);
  assign w_push     = disp_valid && disp_ready &&
                      ((disp_opcode == LS_OP_LOAD) || (disp_opcode == LS_OP_STORE));

  always_comb begin
    w_dispatch_entry           = '0;
    w_dispatch_entry.valid     = 1'b1;
    w_dispatch_entry.op        = disp_opcode;
    w_dispatch_entry.tag       = disp_tag;
    w_dispatch_entry.base      = disp_base_val;
    w_dispatch_entry.base_tag  = disp_base_tag;
    w_dispatch_entry.sdata     = disp_sdata_val;
    w_dispatch_entry.sdata_tag = disp_sdata_tag;
    w_dispatch_entry.imm       = disp_imm;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      lsq_entry u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_wr        (w_push && (r_tail == PTR_W'(gi))),
        .i_wr_entry  (w_dispatch_entry),
        .i_clr       (w_pop && (r_head == PTR_W'(gi))),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .i_cdb_data  (cdb_data),
        .o_entry     (w_slot_flat[gi])
      );
    end
  endgenerate

  assign w_head       = lsq_entry_t'(w_slot_flat[r_head]);
  assign w_head_ready = entry_issuable(w_head);

  // Stores complete in one cycle on mem_done; loads take a second cycle with
  // LS_done raised so Data_Memory presents its registered read data.
  always_comb begin
    w_ls_ready   = 1'b0;
    w_ls_done    = 1'b0;
    w_pop        = 1'b0;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_head_ready) begin
          w_ls_ready = 1'b1;
          if (w_head.op == LS_OP_STORE) begin
            w_pop = mem_done;
          end else if (mem_ls_ready_back) begin
            w_state_next = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        w_ls_ready   = 1'b1;
        w_ls_done    = 1'b1;
        w_pop        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_ls_ready = w_ls_ready;
  assign mem_ls_done  = w_ls_done;
  assign mem_opcode   = w_ls_ready ? w_head.op : LS_OP_NONE;
  assign mem_address  = w_ls_ready ? (w_head.base + w_head.imm) : '0;
  assign mem_data     = w_ls_ready ? w_head.sdata : '0;
  assign mem_tag      = w_ls_ready ? w_head.tag : '0;

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model.
module tb_load_store_queue;

  localparam int DEPTH = 4;
  localparam int TW    = 6;
  localparam int DW    = 32;

  logic          clk;
  logic          rst;
  logic          disp_valid;
  logic          disp_ready;
  logic [1:0]    disp_opcode;
  logic [TW-1:0] disp_tag;
  logic [DW-1:0] disp_base_val;
  logic [TW-1:0] disp_base_tag;
  logic [DW-1:0] disp_sdata_val;
  logic [TW-1:0] disp_sdata_tag;
  logic [DW-1:0] disp_imm;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0]    mem_opcode;
  logic [DW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic [TW-1:0] mem_tag;
  logic          mem_ls_ready;
  logic          mem_ls_done;
  logic          mem_ls_ready_back;
  logic          mem_done;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .disp_valid        (disp_valid),
    .disp_ready        (disp_ready),
    .disp_opcode       (disp_opcode),
    .disp_tag          (disp_tag),
    .disp_base_val     (disp_base_val),
    .disp_base_tag     (disp_base_tag),
    .disp_sdata_val    (disp_sdata_val),
    .disp_sdata_tag    (disp_sdata_tag),
    .disp_imm          (disp_imm),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .mem_opcode        (mem_opcode),
    .mem_address       (mem_address),
    .mem_data          (mem_data),
    .mem_tag           (mem_tag),
    .mem_ls_ready      (mem_ls_ready),
    .mem_ls_done       (mem_ls_done),
    .mem_ls_ready_back (mem_ls_ready_back),
    .mem_done          (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of pending ops plus a flag for "load in its data cycle".
  typedef struct {
    logic [1:0]    op;
    logic [TW-1:0] tag;
    logic [DW-1:0] base;
    logic [TW-1:0] btag;
    logic [DW-1:0] sdata;
    logic [TW-1:0] stag;
    logic [DW-1:0] imm;
  } m_entry_t;

  m_entry_t mq[$];
  bit       m_load_wait = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic bit m_head_ready();
    if (mq.size() == 0) return 1'b0;
    return (mq[0].btag == 0) && ((mq[0].op != 2'b10) || (mq[0].stag == 0));
  endfunction

  function automatic m_entry_t m_snoop(input m_entry_t e);
    m_entry_t r = e;
    if (cdb_valid && (cdb_tag != 0)) begin
      if (r.btag == cdb_tag) begin r.base = cdb_data;  r.btag = 0; end
      if (r.stag == cdb_tag) begin r.sdata = cdb_data; r.stag = 0; end
    end
    return r;
  endfunction

  task automatic check_outputs();
    bit       active;
    m_entry_t h;
    h = '{default: '0};
    if (mq.size() > 0) h = mq[0];
    active = m_load_wait || m_head_ready();
    check_eq("disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH));
    check_eq("ls_ready",   64'(mem_ls_ready), 64'(active));
    check_eq("ls_done",    64'(mem_ls_done),  64'(m_load_wait));
    check_eq("opcode",     64'(mem_opcode),   active ? 64'(h.op) : 64'd0);
    check_eq("address",    64'(mem_address),  active ? 64'(DW'(h.base + h.imm)) : 64'd0);
    check_eq("data",       64'(mem_data),     active ? 64'(h.sdata) : 64'd0);
    check_eq("tag",        64'(mem_tag),      active ? 64'(h.tag) : 64'd0);
  endtask

  task automatic model_edge();
    bit       pop;
    int       pre;
    m_entry_t e;
    if (rst) begin
      mq.delete();
      m_load_wait = 1'b0;
      return;
    end
    pre = mq.size();
    pop = 1'b0;
    if (m_load_wait) begin
      pop = 1'b1;
      m_load_wait = 1'b0;
    end else if (m_head_ready()) begin
      if (mq[0].op == 2'b10) pop = mem_done;
      else if (mem_ls_ready_back) m_load_wait = 1'b1;
    end
    foreach (mq[i]) mq[i] = m_snoop(mq[i]);
    if (pop) void'(mq.pop_front());
    if (disp_valid && (pre < DEPTH) && ((disp_opcode == 2'b01) || (disp_opcode == 2'b10))) begin
      e.op = disp_opcode;   e.tag = disp_tag;
      e.base = disp_base_val;   e.btag = disp_base_tag;
      e.sdata = disp_sdata_val; e.stag = disp_sdata_tag;
      e.imm = disp_imm;
      mq.push_back(m_snoop(e));
    end
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0;        disp_valid = 1'b0;     disp_opcode = 2'b00;
    disp_tag = '0;     disp_base_val = '0;    disp_base_tag = '0;
    disp_sdata_val = '0; disp_sdata_tag = '0; disp_imm = '0;
    cdb_valid = 1'b0;  cdb_tag = '0;          cdb_data = '0;
    mem_ls_ready_back = 1'b0; mem_done = 1'b0;
  endtask

  task automatic set_disp(input logic [1:0] op, input logic [TW-1:0] tag,
                          input logic [DW-1:0] base, input logic [TW-1:0] btag,
                          input logic [DW-1:0] sdata, input logic [TW-1:0] stag,
                          input logic [DW-1:0] imm);
    disp_valid = 1'b1; disp_opcode = op; disp_tag = tag;
    disp_base_val = base; disp_base_tag = btag;
    disp_sdata_val = sdata; disp_sdata_tag = stag; disp_imm = imm;
  endtask

  function automatic logic [TW-1:0] rand_src_tag();
    if ($urandom_range(0, 2) == 0) return TW'($urandom_range(1, 15));
    return '0;
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ls_ready", 64'(mem_ls_ready), 64'd0);
    check_eq("rst_disp_ready", 64'(disp_ready), 64'd1);
    step();

    // Store with ready operands, completed by mem_done.
    set_disp(2'b10, 6'd5, 32'h1000, 6'd0, 32'hDEADBEEF, 6'd0, 32'd4);
    step();
    idle_inputs();
    check_eq("st_opcode", 64'(mem_opcode), 64'h2);
    check_eq("st_addr",   64'(mem_address), 64'h1004);
    check_eq("st_data",   64'(mem_data), 64'hDEADBEEF);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    check_eq("st_empty", 64'(mem_ls_ready), 64'd0);
    step();

    // Load handshake: address cycle, data cycle, then idle.
    set_disp(2'b01, 6'd9, 32'h2000, 6'd0, 32'd0, 6'd0, 32'hFFFF_FFF8);
    step();
    idle_inputs();
    mem_ls_ready_back = 1'b1;
    check_eq("ld_opcode", 64'(mem_opcode), 64'h1);
    check_eq("ld_addr",   64'(mem_address), 64'h1FF8);
    check_eq("ld_done0",  64'(mem_ls_done), 64'd0);
    step();
    mem_ls_ready_back = 1'b0;
    check_eq("ld_done1", 64'(mem_ls_done), 64'd1);
    check_eq("ld_tag",   64'(mem_tag), 64'd9);
    step();
    check_eq("ld_idle", 64'(mem_ls_ready), 64'd0);
    step();

    // Pending base blocks a younger ready store until the CDB supplies it.
    set_disp(2'b01, 6'd3, 32'h0, 6'd12, 32'd0, 6'd0, 32'h10);
    step();
    set_disp(2'b10, 6'd4, 32'h500, 6'd0, 32'h1, 6'd0, 32'd0);
    mem_done = 1'b1; mem_ls_ready_back = 1'b1;
    check_eq("pend_block0", 64'(mem_ls_ready), 64'd0);
    step();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'h3000;
    check_eq("pend_block1", 64'(mem_ls_ready), 64'd0);
    step();
    cdb_valid = 1'b0;
    check_eq("pend_opcode", 64'(mem_opcode), 64'h1);
    check_eq("pend_addr",   64'(mem_address), 64'h3010);
    step();
    step();
    check_eq("pend_store_next", 64'(mem_tag), 64'd4);
    step();
    idle_inputs();
    step();

    // Fill to DEPTH, drop the extra dispatch, then wrap the pointers.
    for (int i = 0; i < 4; i++) begin
      set_disp(2'b10, TW'(20 + i), 32'(i * 16), 6'd0, 32'(i), 6'd0, 32'd0);
      step();
    end
    check_eq("full_ready", 64'(disp_ready), 64'd0);
    set_disp(2'b10, 6'd24, 32'h0, 6'd0, 32'h0, 6'd0, 32'd0);
    step();
    disp_valid = 1'b0;
    mem_done = 1'b1;
    check_eq("drain_t20", 64'(mem_tag), 64'd20);
    step();
    check_eq("drain_t21", 64'(mem_tag), 64'd21);
    step();
    mem_done = 1'b0;
    set_disp(2'b10, 6'd25, 32'h40, 6'd0, 32'h5, 6'd0, 32'd0);
    step();
    set_disp(2'b10, 6'd26, 32'h50, 6'd0, 32'h6, 6'd0, 32'd0);
    step();
    disp_valid = 1'b0;
    mem_done = 1'b1;
    check_eq("wrap_t22", 64'(mem_tag), 64'd22); step();
    check_eq("wrap_t23", 64'(mem_tag), 64'd23); step();
    check_eq("wrap_t25", 64'(mem_tag), 64'd25); step();
    check_eq("wrap_t26", 64'(mem_tag), 64'd26); step();
    check_eq("wrap_empty", 64'(mem_ls_ready), 64'd0);
    idle_inputs();
    step();

    // Same-cycle dispatch and CDB broadcast of the store data.
    set_disp(2'b10, 6'd30, 32'h100, 6'd0, 32'h999, 6'd7, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h55;
    step();
    idle_inputs();
    check_eq("bypass_data", 64'(mem_data), 64'h55);
    mem_done = 1'b1;
    step();
    idle_inputs();

    // Reset while a load is in its data cycle, with a store queued behind.
    set_disp(2'b01, 6'd11, 32'h800, 6'd0, 32'd0, 6'd0, 32'd0);
    step();
    set_disp(2'b10, 6'd12, 32'h900, 6'd0, 32'h7, 6'd0, 32'd0);
    mem_ls_ready_back = 1'b1;
    step();
    idle_inputs();
    check_eq("rstld_done", 64'(mem_ls_done), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_done = 1'b1;
    check_eq("rstld_ready", 64'(mem_ls_ready), 64'd0);
    check_eq("rstld_disp",  64'(disp_ready), 64'd1);
    step();
    idle_inputs();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      disp_valid = ($urandom_range(0, 9) < 6);
      disp_opcode = 2'($urandom_range(0, 3));
      disp_tag = TW'($urandom);
      disp_base_val = $urandom;
      disp_base_tag = rand_src_tag();
      disp_sdata_val = $urandom;
      disp_sdata_tag = rand_src_tag();
      disp_imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : -32'($urandom_range(0, 255));
      cdb_valid = ($urandom_range(0, 1) == 1);
      cdb_tag = TW'($urandom_range(0, 15));
      cdb_data = $urandom;
      mem_done = ($urandom_range(0, 3) != 0);
      mem_ls_ready_back = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
- In-order load/store buffer between the reservation-station dispatch stage and Data_Memory. It sits directly upstream of Data_Memory and drives its Opcode, Address, Data_in, Tag_in, LS_ready_in and LS_done_in inputs.
- Holds dispatched memory ops and snoops the CDB for pending base/store-data operands. It computes base+imm and issues the head entry using the memory ready/done handshake.
- Load results return on Data_Memory's Data_out/Tag_out to the CDB arbiter; this block does not carry them.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
TAG_WIDTH, 6, rename tag width; tag 0 means "value present"
DATA_WIDTH, 32, operand/address/data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept (count < DEPTH)
disp_opcode  in  2  2'b01 load, 2'b10 store; other values are ignored
disp_tag  in  TAG_WIDTH  destination tag of the op
disp_base_val  in  DATA_WIDTH  base register value
disp_base_tag  in  TAG_WIDTH  base producer tag, 0 = ready
disp_sdata_val  in  DATA_WIDTH  store data value
disp_sdata_tag  in  TAG_WIDTH  store data producer tag, 0 = ready
disp_imm  in  DATA_WIDTH  sign-extended offset
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_WIDTH  CDB tag
cdb_data  in  DATA_WIDTH  CDB value
mem_opcode  out  2  to Data_Memory Opcode
mem_address  out  DATA_WIDTH  to Address
mem_data  out  DATA_WIDTH  to Data_in
mem_tag  out  TAG_WIDTH  to Tag_in
mem_ls_ready  out  1  to LS_ready_in
mem_ls_done  out  1  to LS_done_in
mem_ls_ready_back  in  1  from LS_ready_out
mem_done  in  1  from LS_done_out

Behaviour:
- Reset: clears the queue (head=tail=count=0) and sets FSM to IDLE. All mem_* outputs read 0 in the cycle after rst is sampled. Reset during a load aborts it with no pop; the memory sees LS_ready_in=0 next cycle.
- Enqueue: when disp_valid & disp_ready & opcode∈{01,10}, write the entry at tail; tail wraps modulo DEPTH.
- Full queue: disp_ready=0 and dispatch is dropped. There is no same-cycle pop/push bypass.
- Operand capture:
  - Each cycle, every valid entry with a nonzero pending tag equal to cdb_tag (cdb_valid=1) captures cdb_data and clears that tag.
  - A dispatching entry whose disp_*_tag matches the same-cycle CDB broadcast captures cdb_data.
  - A CDB tag of 0 never matches.
- Head readiness: head is ready when base_tag==0, and additionally sdata_tag==0 for a store. Address = base + imm, modulo 2^DATA_WIDTH.
- mem_address, mem_data, mem_tag and mem_opcode are taken combinationally from the head entry while mem_ls_ready=1, and are 0 otherwise.
- FSM:
  - IDLE, head valid & ready, store:
    - Drive mem_opcode=10, mem_ls_ready=1, mem_ls_done=0.
    - When mem_done=1, pop the head at the clock edge and stay in IDLE.
    - Back-to-back stores therefore issue at 1 per cycle.
  - IDLE, head valid & ready, load:
    - Drive mem_opcode=01, mem_ls_ready=1, mem_ls_done=0.
    - When mem_ls_ready_back=1, go to LOAD_WAIT.
  - LOAD_WAIT:
    - Drive the same head with mem_ls_ready=1 and mem_ls_done=1. Data_Memory's synchronous Q is valid this cycle, and it outputs mem_tag on Tag_out.
    - Pop the head at the edge and return to IDLE.
    - A load therefore occupies 2 cycles.
  - IDLE, head empty or not ready: all mem_* outputs are 0.
- Ordering: strictly in order. A younger ready op never bypasses a non-ready head.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package:
  - Opcode constants LS_OP_LOAD=2'b01, LS_OP_STORE=2'b10, LS_OP_NONE=2'b00.
  - TAG_READY=0.
  - FSM state encoding IDLE/LOAD_WAIT.
  - Entry struct: valid, op, tag, base, base_tag, sdata, sdata_tag, imm.
- One natural sub-module: lsq_entry, a single slot register with CDB snoop/capture logic, instantiated DEPTH times.
- Head selection, FSM and pointer logic stay in the top module.

Test Plan:
- Store, operands ready: dispatch store tag=5, base=0x1000, imm=4, sdata=0xDEADBEEF → next cycle mem_opcode=10, mem_address=0x1004, mem_data=0xDEADBEEF, mem_ls_ready=1; with mem_done=1 the queue empties after 1 cycle.
- Load handshake: dispatch load tag=9, base=0x2000, imm=-8 → cycle1 mem_opcode=01, mem_address=0x1FF8, ls_ready=1, ls_done=0; cycle2 ls_done=1, mem_tag=9; cycle3 all mem_* outputs 0.
- Pending operand: dispatch load with base_tag=12 → no issue. cdb_valid=1, cdb_tag=12, cdb_data=0x3000 → load issues next cycle at 0x3000+imm. A younger ready store dispatched behind it must not issue first.
- Fill and wrap (DEPTH=4): dispatch 4 stores → disp_ready=0 and a 5th dispatch is dropped. Drain 2, then enqueue 2 more → issue order matches dispatch order across the pointer wrap.
- Same-cycle dispatch+CDB: dispatch with sdata_tag=7 while cdb_tag=7, cdb_data=0x55 → the entry issues with mem_data=0x55.
- Reset mid-load: assert rst in LOAD_WAIT → next cycle mem_ls_ready=0 and disp_ready=1; the queue is empty.
